// File: rtl/bcd_seg_scan.sv
// Purpose  : four-digit BCD display scanner for a common-anode seven-segment
//            display. A strobe captures the digits into a tear-free shadow copy.
//            The scanner supports leading-zero blanking and shows a dash for
//            illegal codes.
// Latency  : a captured value reaches the outputs one clk after the strobe,
//            but only if its digit is active. AN/SEG/DP lag the scan index by
//            one clk.
// Backpress: none. The strobe is always accepted and the scan free-runs.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   Upd       - capture strobe for BCD_in / DP_in
//   BCD_in    - digit3..digit0, digit0 = BCD_in[3:0] (rightmost)
//   DP_in     - per-digit decimal point request, bit i = digit i
//   Blank_lz  - 1 = blank leading zeros (live, not shadowed)
//   AN        - anode enables, active-low, bit i = digit i
//   SEG       - segments {g,f,e,d,c,b,a}, active-low
//   DP        - decimal point segment, active-low
module bcd_seg_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int PW       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Upd,
  input  logic [15:0] BCD_in,
  input  logic [3:0]  DP_in,
  input  logic        Blank_lz,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam logic [PW-1:0] LP_PRE_LAST = PW'(SCAN_DIV - 1);

  logic [15:0]   r_shadow;
  logic [3:0]    r_shadow_dp;
  logic [PW-1:0] r_pre;
  logic [1:0]    r_idx;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic [3:0]    w_digit;
  logic [6:0]    w_seg;
  logic [3:0]    w_sig;
  logic [3:0]    w_blank;

  assign w_digit = r_shadow[{r_idx, 2'b00} +: 4];

  // A digit is significant when its value is non-zero or it carries a
  // decimal point. A zero digit is blanked only when nothing above it is
  // significant, so the OR chain runs downward from the thousands digit.
  always_comb begin
    w_sig = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w_sig[i] = (r_shadow[4*i +: 4] != 4'd0) | r_shadow_dp[i];
    end
  end

  assign w_blank[3] = Blank_lz & ~w_sig[3];
  assign w_blank[2] = Blank_lz & ~(w_sig[3] | w_sig[2]);
  assign w_blank[1] = Blank_lz & ~(w_sig[3] | w_sig[2] | w_sig[1]);
  assign w_blank[0] = 1'b0;

  always_comb begin
    w_seg = 7'b0111111;  // dash for codes 10..15
    case (w_digit)
      4'd0: w_seg = 7'b1000000;
      4'd1: w_seg = 7'b1111001;
      4'd2: w_seg = 7'b0100100;
      4'd3: w_seg = 7'b0110000;
      4'd4: w_seg = 7'b0011001;
      4'd5: w_seg = 7'b0010010;
      4'd6: w_seg = 7'b0000010;
      4'd7: w_seg = 7'b1111000;
      4'd8: w_seg = 7'b0000000;
      4'd9: w_seg = 7'b0010000;
      default: w_seg = 7'b0111111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow    <= 16'h0000;
      r_shadow_dp <= 4'b0000;
      r_pre       <= '0;
      r_idx       <= 2'd0;
      r_an        <= 4'b1111;
      r_seg       <= 7'b1111111;
      r_dp        <= 1'b1;
    end else begin
      if (Upd) begin
        r_shadow    <= BCD_in;
        r_shadow_dp <= DP_in;
      end

      if (r_pre == LP_PRE_LAST) begin
        r_pre <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end

      // The outputs come from the pre-edge index and shadow. This keeps each
      // slot exactly SCAN_DIV cycles long and lets new data appear cleanly.
      if (w_blank[r_idx]) begin
        r_an  <= 4'b1111;
        r_seg <= 7'b1111111;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= ~(4'b0001 << r_idx);
        r_seg <= w_seg;
        r_dp  <= ~r_shadow_dp[r_idx];
      end
    end
  end

  assign AN  = r_an;
  assign SEG = r_seg;
  assign DP  = r_dp;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Purpose  : directed self-checking bench for bcd_seg_scan. It instantiates
//            SCAN_DIV=4 and SCAN_DIV=1 copies that share one set of inputs.
// Latency  : outputs are sampled 1 time unit after each rising edge.
// Backpress: not applicable.
module tb_bcd_seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an4, an1;
  logic [6:0]  seg4, seg1;
  logic        dp4, dp1;

  int n_chk = 0;
  int n_err = 0;
  int ecnt  = 0;

  always #5 clk = ~clk;

  bcd_seg_scan #(.SCAN_DIV(4), .PW(3)) dut (
    .clk(clk), .rst(rst), .Upd(upd), .BCD_in(bcd_in), .DP_in(dp_in),
    .Blank_lz(blank_lz), .AN(an4), .SEG(seg4), .DP(dp4)
  );

  bcd_seg_scan #(.SCAN_DIV(1), .PW(1)) dut1 (
    .clk(clk), .rst(rst), .Upd(upd), .BCD_in(bcd_in), .DP_in(dp_in),
    .Blank_lz(blank_lz), .AN(an1), .SEG(seg1), .DP(dp1)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got AN/SEG/DP %b_%b_%b expected %b_%b_%b", tag,
               obs[11:8], obs[7:1], obs[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  // Advance to the first edge of slot s on the SCAN_DIV=4 instance.
  task automatic goto_slot(input int s);
    bit found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (((ecnt - 1) % 4 == 0) && (((ecnt - 1) / 4) % 4 == s)) found = 1;
    end
    if (!found) begin
      n_chk++;
      n_err++;
      $display("FAIL goto_slot%0d: slot start not reached within 40 edges", s);
    end
  endtask

  task automatic slot_chk(input string tag, input int s, input logic [3:0] an,
                          input logic [6:0] seg, input logic dp);
    goto_slot(s);
    chk(tag, {an4, seg4, dp4}, {an, seg, dp});
  endtask

  task automatic strobe(input logic [15:0] v, input logic [3:0] d);
    bcd_in = v;
    dp_in  = d;
    upd    = 1'b1;
    tick();
    upd    = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_an;
    rst = 1'b1; upd = 1'b0; bcd_in = 16'h0000; dp_in = 4'b0000; blank_lz = 1'b0;
    tick();
    chk("reset4", {an4, seg4, dp4}, {4'b1111, 7'b1111111, 1'b1});
    chk("reset1", {an1, seg1, dp1}, {4'b1111, 7'b1111111, 1'b1});
    rst = 1'b0;
    ecnt = 0;

    // Cadence check: each slot lasts four edges, and edge 17 wraps back to slot 0.
    for (int e = 1; e <= 17; e++) begin
      tick();
      exp_an = ~(4'b0001 << (((e - 1) / 4) % 4));
      chk($sformatf("cad4_e%0d", e), {an4, seg4, dp4},
          {exp_an, (e <= 4) ? 7'b1000000 : seg4, 1'b1});
      if (e <= 5) begin
        exp_an = ~(4'b0001 << ((e - 1) % 4));
        chk($sformatf("cad1_e%0d", e), {an1, 7'b0, dp1}, {exp_an, 7'b0, 1'b1});
      end
    end

    // Encoding test: 1234 with a decimal point on digit 2.
    strobe(16'h1234, 4'b0100);
    slot_chk("enc_s0", 0, 4'b1110, 7'b0011001, 1'b1);
    slot_chk("enc_s1", 1, 4'b1101, 7'b0110000, 1'b1);
    slot_chk("enc_s2", 2, 4'b1011, 7'b0100100, 1'b0);
    slot_chk("enc_s3", 3, 4'b0111, 7'b1111001, 1'b1);

    // Illegal codes show a dash. Input changes without Upd are ignored.
    strobe(16'hFA90, 4'b0000);
    bcd_in = 16'h5555;
    slot_chk("tear_s0", 0, 4'b1110, 7'b1000000, 1'b1);
    slot_chk("tear_s1", 1, 4'b1101, 7'b0010000, 1'b1);
    slot_chk("tear_s2", 2, 4'b1011, 7'b0111111, 1'b1);
    slot_chk("tear_s3", 3, 4'b0111, 7'b0111111, 1'b1);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    strobe(16'h0070, 4'b0000);
    slot_chk("lz70_s0", 0, 4'b1110, 7'b1000000, 1'b1);
    slot_chk("lz70_s1", 1, 4'b1101, 7'b1111000, 1'b1);
    slot_chk("lz70_s2", 2, 4'b1111, 7'b1111111, 1'b1);
    slot_chk("lz70_s3", 3, 4'b1111, 7'b1111111, 1'b1);
    strobe(16'h0000, 4'b0000);
    slot_chk("lz00_s0", 0, 4'b1110, 7'b1000000, 1'b1);
    slot_chk("lz00_s1", 1, 4'b1111, 7'b1111111, 1'b1);
    slot_chk("lz00_s2", 2, 4'b1111, 7'b1111111, 1'b1);
    slot_chk("lz00_s3", 3, 4'b1111, 7'b1111111, 1'b1);
    strobe(16'h0005, 4'b0100);
    slot_chk("lzdp_s0", 0, 4'b1110, 7'b0010010, 1'b1);
    slot_chk("lzdp_s1", 1, 4'b1101, 7'b1000000, 1'b1);
    slot_chk("lzdp_s2", 2, 4'b1011, 7'b1000000, 1'b0);
    slot_chk("lzdp_s3", 3, 4'b1111, 7'b1111111, 1'b1);

    // Apply Upd on the edge where the index wraps from 3 to 0.
    blank_lz = 1'b0;
    goto_slot(3);
    tick();
    tick();  // third edge of slot 3; the next edge is the wrap
    strobe(16'h0008, 4'b0001);
    chk("wrap_old_s3", {an4, seg4, dp4}, {4'b0111, 7'b1000000, 1'b1});
    tick();
    chk("wrap_new_s0", {an4, seg4, dp4}, {4'b1110, 7'b0000000, 1'b0});

    // Reset during slot 2.
    goto_slot(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst4", {an4, seg4, dp4}, {4'b1111, 7'b1111111, 1'b1});
    chk("midrst1", {an1, seg1, dp1}, {4'b1111, 7'b1111111, 1'b1});
    ecnt = 0;
    tick();
    chk("post_s0", {an4, seg4, dp4}, {4'b1110, 7'b1000000, 1'b1});
    chk("post1_e1", {an1, seg1, dp1}, {4'b1110, 7'b1000000, 1'b1});
    slot_chk("post_s1", 1, 4'b1101, 7'b1000000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
